// File: rtl/shift164_pkg.sv
// Shared types and constants for the 74LS164 serial loader.
// Holds the sequencer state encoding, byte geometry and shift-buffer helpers.
package shift164_pkg;

    typedef enum logic [2:0] {
        StClear = 3'd0,
        StIdle  = 3'd1,
        StSetup = 3'd2,
        StHigh  = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned CLK_DIV_MIN   = 1;
    localparam int unsigned CLK_DIV_MAX   = 255;

    // Bit presented on the serial data pins for the current buffer contents.
    function automatic logic cur_bit(input logic [7:0] data, input bit msb_first);
        return msb_first ? data[7] : data[0];
    endfunction

    // Advance the buffer so the next bit to send sits at the presented end.
    function automatic logic [7:0] next_buf(input logic [7:0] data, input bit msb_first);
        return msb_first ? {data[6:0], 1'b0} : {1'b0, data[7:1]};
    endfunction

endpackage

// File: rtl/shift164_loader_phase_timer.sv
// Phase duration down-counter: reloads DIV-1 on phase entry, expire marks the last cycle.
// Counter is cleared by reset and re-arms itself on the first clock afterwards.
module phase_timer
    import shift164_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

    if (DIV < CLK_DIV_MIN || DIV > CLK_DIV_MAX) begin : g_bad_div
        $error("phase_timer: DIV out of range 1..255");
    end

    logic [CW-1:0] r_cnt;
    logic          r_armed;

    // The first edge after reset counts as entry into the post-reset clear phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_load || !r_armed) begin
            r_cnt   <= LOAD_VAL;
            r_armed <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = r_armed && (r_cnt == '0);

endmodule

// File: rtl/shift164_loader.sv
// Serial loader for a 74LS164 shift register: one byte per handshake, plus clear commands.
// All pin-facing outputs are registered from the next state.
module shift164_loader
    import shift164_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       cp,
    input  logic       mr,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clr,
    output logic       busy,
    output logic       done,
    output logic       sr_dsa,
    output logic       sr_dsb,
    output logic       sr_cp,
    output logic       sr_mr_n
);

    if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
        $error("shift164_loader: CLK_DIV out of range 1..255");
    end

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    state_e     r_state;
    state_e     w_state_d;
    logic [7:0] r_buf;
    logic [7:0] w_buf_d;
    logic [2:0] r_bit;
    logic [2:0] w_bit_d;
    logic       w_expire;
    logic       w_load;

    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_ds;
    logic       r_cp;
    logic       r_mr_n;

    phase_timer #(
        .DIV(CLK_DIV)
    ) u_timer (
        .i_clk   (cp),
        .i_rst   (mr),
        .i_load  (w_load),
        .o_expire(w_expire)
    );

    always_comb begin
        w_state_d = r_state;
        w_buf_d   = r_buf;
        w_bit_d   = r_bit;
        unique case (r_state)
            StClear: begin
                if (w_expire) w_state_d = StDone;
            end
            StIdle: begin
                // Clear wins over a simultaneous byte; the byte stays pending.
                if (clr) begin
                    w_state_d = StClear;
                end else if (in_valid) begin
                    w_buf_d   = in_data;
                    w_bit_d   = '0;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                if (w_expire) w_state_d = StHigh;
            end
            StHigh: begin
                if (w_expire) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_d = StDone;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_buf_d   = next_buf(r_buf, MSB_FIRST);
                        w_state_d = StSetup;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StClear;
            end
        endcase
    end

    assign w_load = (w_state_d != r_state);

    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            r_state <= StClear;
            r_buf   <= '0;
            r_bit   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_ds    <= 1'b0;
            r_cp    <= 1'b0;
            r_mr_n  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_buf   <= w_buf_d;
            r_bit   <= w_bit_d;
            r_ready <= (w_state_d == StIdle);
            r_busy  <= (w_state_d != StIdle);
            r_done  <= (w_state_d == StDone);
            r_cp    <= (w_state_d == StHigh);
            r_mr_n  <= (w_state_d != StClear);
            // Data moves only with the falling shift clock, giving CLK_DIV cycles of hold.
            if (w_state_d == StSetup || w_state_d == StHigh) begin
                r_ds <= cur_bit(w_buf_d, MSB_FIRST);
            end
        end
    end

    assign in_ready = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sr_dsa   = r_ds;
    assign sr_dsb   = r_ds;
    assign sr_cp    = r_cp;
    assign sr_mr_n  = r_mr_n;

endmodule
